// File: rtl/vga_pattern_gen.sv
// RGB565 test-pattern source for a pull-style VGA driver: one pixel per data_req cycle,
// registered with one cycle of latency, selectable between bars, checkerboard, gradient, solid.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BAR_W    = 80
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        data_req,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    input  logic        clr,
    output logic [15:0] data,
    output logic        frame_done
);

    // Counters are at least 8 bits wide so the gradient can always slice x[7:3] and y[7:2].
    localparam int unsigned XW = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
    localparam int unsigned YW = ($clog2(V_ACTIVE) > 8) ? $clog2(V_ACTIVE) : 8;
    localparam int unsigned SW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

    typedef enum logic [1:0] {
        ModeBars     = 2'd0,
        ModeChecker  = 2'd1,
        ModeGradient = 2'd2,
        ModeSolid    = 2'd3
    } mode_e;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;
    mode_e         mode_q, mode_d;
    logic [15:0]   solid_q, solid_d;
    logic [15:0]   data_q, data_d;
    logic          frame_done_q, frame_done_d;

    logic          frame_start;
    logic          x_last;
    logic          y_last;
    mode_e         mode_eff;
    logic [15:0]   solid_eff;
    logic [15:0]   bar_color;
    logic [15:0]   pixel;

    assign frame_start = (x_q == '0) && (y_q == '0);
    assign x_last      = (x_q == X_LAST);
    assign y_last      = (y_q == Y_LAST);

    // The first pixel of a frame uses the live inputs; everything after uses the latched copy.
    assign mode_eff  = frame_start ? mode_e'(mode) : mode_q;
    assign solid_eff = frame_start ? solid_color : solid_q;

    always_comb begin
        bar_color = 16'h0000;
        unique case (bar_q)
            3'd0: bar_color = 16'hFFFF;
            3'd1: bar_color = 16'hFFE0;
            3'd2: bar_color = 16'h07FF;
            3'd3: bar_color = 16'h07E0;
            3'd4: bar_color = 16'hF81F;
            3'd5: bar_color = 16'hF800;
            3'd6: bar_color = 16'h001F;
            3'd7: bar_color = 16'h0000;
            default: bar_color = 16'h0000;
        endcase
    end

    always_comb begin
        pixel = 16'h0000;
        unique case (mode_eff)
            ModeBars:     pixel = bar_color;
            ModeChecker:  pixel = (x_q[5] ^ y_q[5]) ? 16'hFFFF : 16'h0000;
            ModeGradient: pixel = {x_q[7:3], y_q[7:2], ~x_q[7:3]};
            ModeSolid:    pixel = solid_eff;
            default:      pixel = 16'h0000;
        endcase
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        sub_d        = sub_q;
        bar_d        = bar_q;
        mode_d       = mode_q;
        solid_d      = solid_q;
        data_d       = data_q;
        frame_done_d = 1'b0;

        if (clr) begin
            x_d   = '0;
            y_d   = '0;
            sub_d = '0;
            bar_d = '0;
        end else if (data_req) begin
            data_d       = pixel;
            frame_done_d = x_last && y_last;
            if (frame_start) begin
                mode_d  = mode_eff;
                solid_d = solid_eff;
            end
            if (x_last) begin
                x_d   = '0;
                sub_d = '0;
                bar_d = '0;
                y_d   = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
                // Bar index advances every BAR_W pixels without dividing x.
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    bar_d = bar_q + 3'd1;
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            sub_q        <= '0;
            bar_q        <= '0;
            mode_q       <= ModeBars;
            solid_q      <= 16'h0000;
            data_q       <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            sub_q        <= sub_d;
            bar_q        <= bar_d;
            mode_q       <= mode_d;
            solid_q      <= solid_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data       = data_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter BAR_W, default 80: colour-bar width in pixels; H_ACTIVE = 8*BAR_W is required.
REQ-004 SHALL have port sys_clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port data_req, input, 1: pixel request from the downstream VGA driver, one pixel per high cycle.
REQ-007 SHALL have port data, output, 16: RGB565 pixel, red [15:11], green [10:5], blue [4:0].
REQ-008 SHALL have port mode, input, 2: pattern select, 0 bars, 1 checkerboard, 2 gradient, 3 solid.
REQ-009 SHALL have port solid_color, input, 16: RGB565 value used in mode 3.
REQ-010 SHALL have port clr, input, 1: synchronous resync of pixel position to frame start.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is produced.

Function
REQ-012 SHALL keep position counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1), both 0 at frame start.
REQ-013 SHALL, on each cycle with data_req=1 and clr=0, register the pixel for current (x,y) into data on that rising edge, so data is valid the cycle after the request (latency 1).
REQ-014 SHALL hold data unchanged on cycles with data_req=0.
REQ-015 SHALL, on each accepted request, increment x; at x=H_ACTIVE-1, wrap x to 0 and increment y; at x=H_ACTIVE-1 and y=V_ACTIVE-1, wrap both to 0.
REQ-016 SHALL latch mode and solid_color into internal registers when a request is accepted at (0,0), using the newly latched values for that pixel; mid-frame changes on mode/solid_color SHALL have no effect until the next frame.
REQ-017 SHALL in mode 0 output 8 vertical bars of BAR_W pixels, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (hex).
REQ-018 SHALL derive the bar index from a bar sub-counter (0..BAR_W-1) and a 3-bit bar counter advanced with x, with no divider; both reset at x wrap.
REQ-019 SHALL in mode 1 output FFFF when x[5] XOR y[5] = 1, else 0000 (32x32 squares, top-left square black).
REQ-020 SHALL in mode 2 output red = x[7:3], green = y[7:2], blue = ~x[7:3] (5-bit inversion).
REQ-021 SHALL in mode 3 output the latched solid_color.
REQ-022 SHALL assert frame_done for exactly one cycle, on the same edge that registers the pixel at (H_ACTIVE-1, V_ACTIVE-1).
REQ-023 SHALL, when clr=1, set x, y, bar sub-counter and bar counter to 0 on that edge, leave data unchanged, and not assert frame_done.
REQ-024 SHALL give clr priority over data_req when both are 1: no pixel produced, counters cleared.
REQ-025 SHALL, after clr, treat the next accepted request as frame start (mode/solid_color relatched per REQ-016).

Reset
REQ-026 SHALL, while rst_n=0, force data=16'h0000, frame_done=0, x=0, y=0, bar counters=0, latched mode=0, latched solid_color=16'h0000, regardless of clock.
REQ-027 SHALL, after rst_n deassertion, accept requests from the first rising edge, starting at (0,0); reset mid-frame SHALL discard position, with no partial-frame pulse.

Verification
REQ-028 SHALL cover reset: hold rst_n=0 with data_req toggling -> data=0000, frame_done=0 throughout; first req after release yields pixel (0,0).
REQ-029 SHALL cover mode 0, data_req held high for one line -> data 1 cycle after req: FFFF for pixels 0..79, FFE0 for 80..159, ..., 0000 for 560..639; pixel 640 is FFFF (line 1).
REQ-030 SHALL cover gapped requests (random data_req duty) in mode 1 -> pixel sequence identical to the gapless run; data stable during gaps; (32,0)=FFFF, (32,32)=0000.
REQ-031 SHALL cover full frame in mode 2 -> frame_done high exactly once, on the cycle after request 307199; next pixel is (0,0)={5'h00,6'h00,5'h1F}=001F.
REQ-032 SHALL cover mode change mid-frame: switch 0->3 with solid_color=1234 at pixel 1000 -> bars continue to frame end; next frame all 1234.
REQ-033 SHALL cover clr with data_req=1 at pixel 500 -> data holds previous value, no frame_done; next request outputs pixel (0,0).
